// File: rtl/sr_pkg.sv
// Shared constants and state encoding for the configuration
// shift-register readback and write-side blocks.
package sr_pkg;

    localparam int SR_WIDTH     = 170;
    localparam int SR_CNT_WIDTH = 8;
    localparam int SR_DIV_WIDTH = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } sr_state_t;

endpackage

// File: rtl/sr_phase_gen.sv
// Divided shift-clock generator: phase counter, latched divider,
// registered clk_sr_rd and a sample strobe at the end of each low phase.
module sr_phase_gen
    import sr_pkg::*;
#(
    parameter int DIV_WIDTH = SR_DIV_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 clk_sr_rd,
    output logic                 sample
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] phase;
    logic [DIV_WIDTH-1:0] phase_nxt;
    logic [DIV_WIDTH-1:0] mask;
    logic [DIV_WIDTH-1:0] half;

    // Effective divider: 0 acts as 1; values beyond the counter width saturate.
    always_comb begin
        div_eff = div;
        if (div == '0) begin
            div_eff = DIV_WIDTH'(1);
        end else if (div > DIV_WIDTH'(DIV_WIDTH)) begin
            div_eff = DIV_WIDTH'(DIV_WIDTH);
        end
    end

    // Period mask, its top bit, next phase and the end-of-period strobe.
    always_comb begin
        mask      = ~({DIV_WIDTH{1'b1}} << div_q);
        half      = mask ^ (mask >> 1);
        phase_nxt = (phase + DIV_WIDTH'(1)) & mask;
        sample    = run && (phase == mask);
    end

    // Divider latch, phase counter and glitch-free registered shift clock.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q     <= DIV_WIDTH'(1);
            phase     <= '0;
            clk_sr_rd <= 1'b1;
        end else begin
            if (load) begin
                div_q <= div_eff;
                phase <= '0;
            end else if (run) begin
                phase <= phase_nxt;
            end
            clk_sr_rd <= run ? ~|(phase_nxt & half) : 1'b1;
        end
    end

endmodule

// File: rtl/sr_readback_rx.sv
// Readback receiver: drives the divided shift clock and deserializes
// WIDTH bits MSB first, then strobes data_valid for one cycle.
module sr_readback_rx
    import sr_pkg::*;
#(
    parameter int WIDTH     = SR_WIDTH,
    parameter int CNT_WIDTH = SR_CNT_WIDTH,
    parameter int DIV_WIDTH = SR_DIV_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 sr_dout,
    output logic                 clk_sr_rd,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] bit_count
);

    sr_state_t        state;
    sr_state_t        state_nxt;
    logic             load;
    logic             run;
    logic             sample;
    logic             last;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;

    assign run        = (state == SHIFT);
    assign load       = (state == IDLE) && start;
    assign last       = sample && (bit_count == CNT_WIDTH'(WIDTH - 1));
    assign shreg_nxt  = {shreg[WIDTH-2:0], sr_dout};
    assign data_valid = (state == DONE);
    assign busy       = run || data_valid;

    sr_phase_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_phase (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (load),
        .run      (run),
        .div      (div),
        .clk_sr_rd(clk_sr_rd),
        .sample   (sample)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, sample counter and held output word.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_count <= '0;
            data_out  <= '0;
        end else if (load) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (sample) begin
            shreg     <= shreg_nxt;
            bit_count <= bit_count + CNT_WIDTH'(1);
            if (last) begin
                data_out <= shreg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sr_readback_rx.sv
// Randomized bench for sr_readback_rx with a chip model and a
// cycle-level reference derived from elapsed time since start.
module tb_sr_readback_rx;
    localparam int W = 170;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   div = 6'd1;
    logic         sr_dout = 1'b0;
    logic         clk_sr_rd;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic [7:0]   bit_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    sr_readback_rx dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .div       (div),
        .sr_dout   (sr_dout),
        .clk_sr_rd (clk_sr_rd),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .bit_count (bit_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Chip model: presents the next bit, MSB first, on each falling shift clock.
    logic [W-1:0] chip_pat;
    int           chip_idx = 0;
    always @(negedge clk_sr_rd) begin
        if (chip_idx > 0) begin
            chip_idx = chip_idx - 1;
            sr_dout  = chip_pat[chip_idx];
        end
    end

    // Reference model: tracks edges elapsed since the accepted start.
    logic [W-1:0] next_pat;
    logic [W-1:0] m_pat;
    logic [W-1:0] m_data = '0;
    bit           m_active = 0;
    int           m_e = 0;
    int           m_p = 2;
    int           m_bc_idle = 0;
    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_active  = 0;
            m_bc_idle = 0;
            m_data    = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_e      = 0;
                m_p      = 1 << ((div == 0) ? 1 : int'(div));
                m_pat    = next_pat;
            end
        end else begin
            m_e++;
            if (m_e == W * m_p) begin
                m_data = m_pat;
            end else if (m_e > W * m_p) begin
                m_active  = 0;
                m_bc_idle = W;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        logic       e_clk, e_busy, e_dv;
        logic [7:0] e_bc;
        if (armed && !rst) begin
            e_clk  = 1'b1;
            e_busy = 1'b0;
            e_dv   = 1'b0;
            e_bc   = 8'(m_bc_idle);
            if (m_active) begin
                e_busy = 1'b1;
                if (m_e < W * m_p) begin
                    e_clk = ((m_e % m_p) < (m_p / 2));
                    e_bc  = 8'(m_e / m_p);
                end else begin
                    e_dv = 1'b1;
                    e_bc = 8'(W);
                end
            end
            chk("clk_sr_rd", 256'(clk_sr_rd), 256'(e_clk));
            chk("busy", 256'(busy), 256'(e_busy));
            chk("data_valid", 256'(data_valid), 256'(e_dv));
            chk("bit_count", 256'(bit_count), 256'(e_bc));
            chk("data_out", 256'(data_out), 256'(m_data));
        end
    end

    function automatic logic [W-1:0] rnd_pat();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
        return t[W-1:0];
    endfunction

    task automatic load_chip(input logic [W-1:0] p);
        next_pat = p;
        chip_pat = p;
        chip_idx = W;
    endtask

    // One readback; reports latency in edges, busy cycles and low pulses.
    task automatic run_rb(input int d, input logic [W-1:0] p, input bit noise,
                          output int lat, output int busy_n, output int lows);
        bit prev;
        lat    = -1;
        busy_n = 0;
        lows   = 0;
        prev   = 1'b1;
        @(negedge clk_in);
        #1;
        div = 6'(d);
        load_chip(p);
        start = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk_in);
            if (busy) busy_n++;
            if (!clk_sr_rd && prev) lows++;
            prev = clk_sr_rd;
            if (data_valid) begin
                lat = c;
                break;
            end
            #1;
            start = 1'b0;
            if (noise && c >= 10 && c < 200 && (c % 37) == 0) begin
                start = 1'b1;
                div   = 6'd5;
            end
        end
        #1;
        start = 1'b0;
    endtask

    initial begin
        int           lat, bn, lw, d, dvn;
        bit           got;
        logic [W-1:0] pa, pb, p1;

        repeat (3) @(negedge clk_in);
        chk("rst_clk", 256'(clk_sr_rd), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_dv", 256'(data_valid), 256'(0));
        chk("rst_bc", 256'(bit_count), 256'(0));
        chk("rst_data", 256'(data_out), 256'(0));
        #1;
        rst   = 1'b0;
        armed = 1;

        p1 = {2'b10, {21{8'hA5}}};
        run_rb(1, p1, 0, lat, bn, lw);
        chk("d1_latency", 256'(lat), 256'(340));
        chk("d1_lows", 256'(lw), 256'(170));
        chk("d1_data", 256'(data_out), 256'(p1));

        run_rb(3, rnd_pat(), 0, lat, bn, lw);
        chk("d3_latency", 256'(lat), 256'(1360));
        chk("d3_busy", 256'(bn), 256'(1361));
        chk("d3_lows", 256'(lw), 256'(170));

        run_rb(0, rnd_pat(), 0, lat, bn, lw);
        chk("d0_latency", 256'(lat), 256'(340));
        chk("d0_lows", 256'(lw), 256'(170));

        run_rb(1, rnd_pat(), 1, lat, bn, lw);
        chk("noise_latency", 256'(lat), 256'(340));
        dvn = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (data_valid) dvn++;
        end
        chk("noise_extra_dv", 256'(dvn), 256'(0));

        @(negedge clk_in);
        #1;
        div = 6'd2;
        load_chip(rnd_pat());
        start = 1'b1;
        @(negedge clk_in);
        #1;
        start = 1'b0;
        repeat (200) @(negedge clk_in);
        chk("pre_rst_bc", 256'(bit_count), 256'(50));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_clk", 256'(clk_sr_rd), 256'(1));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_dv", 256'(data_valid), 256'(0));
        chk("arst_bc", 256'(bit_count), 256'(0));
        chk("arst_data", 256'(data_out), 256'(0));
        @(negedge clk_in);
        #1;
        rst = 1'b0;
        pa  = rnd_pat();
        run_rb(2, pa, 0, lat, bn, lw);
        chk("post_rst_latency", 256'(lat), 256'(680));
        chk("post_rst_data", 256'(data_out), 256'(pa));

        @(negedge clk_in);
        #1;
        div = 6'd1;
        pa  = rnd_pat();
        load_chip(pa);
        start = 1'b1;
        got   = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk_in);
            if (data_valid) got = 1;
        end
        chk("held_first_dv", 256'(got), 256'(1));
        #1;
        pb = rnd_pat();
        load_chip(pb);
        @(negedge clk_in);
        chk("held_idle_gap", 256'(busy), 256'(0));
        @(negedge clk_in);
        chk("held_restart", 256'(busy), 256'(1));
        chk("held_keep_data", 256'(data_out), 256'(pa));
        #1;
        start = 1'b0;
        got   = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk_in);
            if (data_valid) got = 1;
        end
        chk("held_second_dv", 256'(got), 256'(1));
        chk("held_second_data", 256'(data_out), 256'(pb));

        for (int i = 0; i < 4; i++) begin
            d  = $urandom_range(0, 3);
            pa = rnd_pat();
            run_rb(d, pa, 0, lat, bn, lw);
            chk("rnd_latency", 256'(lat), 256'(W << ((d == 0) ? 1 : d)));
            chk("rnd_data", 256'(data_out), 256'(pa));
        end

        repeat (4) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sr_readback_rx.md
Name: sr_readback_rx

Overview:
Readback end of the configuration shift-register interface. After a `start` pulse, the block drives its own gated, divided shift clock `clk_sr_rd` to the chip. It samples the chip's serial output `sr_dout` once per shift-clock period and deserializes WIDTH bits, MSB first, into a parallel word. It then presents the word with a one-cycle `data_valid` strobe. It sits beside the write-side clock/shift logic, sharing the same `clk_in` and division scheme, so a written pattern can be read back and compared.

Parameters:
WIDTH, 170, number of bits captured per readback
CNT_WIDTH, 8, width of bit counter; 2**CNT_WIDTH > WIDTH
DIV_WIDTH, 6, width of division factor; shift period = 2**div clk_in cycles

Ports:
clk_in  input  1  block clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; accepted only in IDLE
div  input  DIV_WIDTH  division factor; latched at accepted start; 0 treated as 1
sr_dout  input  1  serial data from chip, already synchronous to clk_in
clk_sr_rd  output  1  shift clock to chip; idles high
data_out  output  WIDTH  captured word; first sampled bit lands in bit WIDTH-1
data_valid  output  1  one-cycle strobe, data_out valid and stable
busy  output  1  high in SHIFT and DONE
bit_count  output  CNT_WIDTH  samples taken in the current readback

Behaviour:
- Reset values (async, immediate, also mid-operation):
  - state=IDLE, phase counter=0, bit_count=0.
  - clk_sr_rd=1, data_out=0, data_valid=0, busy=0.
  - Any partial capture is discarded.
- States (one-hot): IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start=1. At that edge: div_q<=max(div,1), phase counter<=0, bit_count<=0, shift reg<=0.
  - SHIFT -> DONE at the edge taking sample number WIDTH.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start in SHIFT or DONE is ignored, with no restart and no queuing.
- Phase counter: DIV_WIDTH bits, increments every clk_in in SHIFT, wraps modulo 2**div_q. Changes to div during SHIFT have no effect.
- clk_sr_rd:
  - 1 outside SHIFT.
  - In SHIFT it equals ~phase[div_q-1]: high for the first 2**(div_q-1) cycles of each period, then low for the rest.
  - Exactly WIDTH low pulses per readback.
  - Must come from a flop, so it is glitch-free.
- Sampling:
  - Sample in the cycle where phase[div_q-1:0] is all ones, i.e. the last cycle of the low phase, just before the rising edge.
  - At that edge: shreg <= {shreg[WIDTH-2:0], sr_dout}, bit_count += 1.
- Timing: the k-th sample edge is k*2**div_q cycles after the start edge, for k=1..WIDTH.
- Completion: at the WIDTH-th sample edge, data_out <= final shreg and state -> DONE. data_valid is high during DONE only.
- Latency: data_valid is high in the cycle WIDTH*2**div_q after the start cycle. The next start is accepted one cycle after data_valid.
- data_out holds its value until the next completed readback. It is not modified during a capture.
- bit_count holds WIDTH in DONE and clears at the next accepted start.

Decomposition:
- Package sr_pkg holds the state encodings (IDLE=3'b001, SHIFT=3'b010, DONE=3'b100) and the default WIDTH/DIV_WIDTH/CNT_WIDTH constants. These are shared with the write-side blocks.
- One sub-module, sr_phase_gen:
  - Contains the phase counter, div_q latch, the registered clk_sr_rd output and the one-cycle sample strobe.
  - The top-level module holds the FSM, shift register and output registers.

Test Plan:
- WIDTH=8, div=1, chip model shifts 0xA5 MSB-first on clk_sr_rd falling edges -> data_out=0xA5, 8 low pulses of 1 cycle each, data_valid high exactly 16 cycles after start.
- WIDTH=170, div=3, random 170-bit pattern -> exact match, data_valid at cycle 1360, clk_sr_rd period 8 (4 high / 4 low), busy high 1361 cycles.
- div=0 with WIDTH=8, pattern 0x3C -> identical timing and result to div=1.
- Extra start pulses during SHIFT, and div changed 1->5 mid-shift -> both ignored, timing per the original div, single data_valid.
- rst asserted after 50 samples (WIDTH=170, div=2) -> all outputs at reset values the same cycle. A following readback of a new pattern is correct with full latency.
- start held high through DONE -> no restart in DONE. New readback begins in the first IDLE cycle, and data_out keeps the previous word until the new data_valid.
